// File: rtl/seq_pkg.sv
// Shared constants for the sequence feeder: base encoding, window depth and FSM states.
package seq_pkg;

  localparam int BASE_W = 3;
  localparam int WIN    = 4;

  localparam logic [BASE_W-1:0] BASE_PAD = 3'd0;
  localparam logic [BASE_W-1:0] BASE_A   = 3'd1;
  localparam logic [BASE_W-1:0] BASE_C   = 3'd2;
  localparam logic [BASE_W-1:0] BASE_G   = 3'd3;
  localparam logic [BASE_W-1:0] BASE_T   = 3'd4;
  localparam logic [BASE_W-1:0] BASE_N   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SETTLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/seq_side_ctrl.sv
// One side (Q or R) of the feeder: length register, RAM read strobe/address and the
// PAD-or-rdata mux that presents the serial base one cycle after the issue.
module seq_side_ctrl
  import seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int KW     = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              issue_i,
  input  logic [KW-1:0]     k_i,
  output logic              rd_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [BASE_W-1:0] rdata_i,
  output logic [BASE_W-1:0] base_o
);

  logic [ADDR_W:0] len_q;
  logic            rd_q;
  logic            in_range;

  assign in_range = (KW'(len_q) > k_i);
  assign rd_o     = issue_i && in_range;
  // Address parks at 0 whenever no read is issued so idle cycles show a clean bus.
  assign addr_o   = rd_o ? k_i[ADDR_W-1:0] : '0;
  assign base_o   = rd_q ? rdata_i : BASE_PAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      if (load_i) begin
        len_q <= len_i;
      end
      rd_q <= rd_o;
    end
  end

endmodule

// File: rtl/seq_feeder.sv
// Sequence feeder: shifts Q/R bases into the window registers and offers each window
// pair downstream. Define SEQ_FEEDER_STATS_EN to add the stall_cnt output.
module seq_feeder
  import seq_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   q_len,
  input  logic [ADDR_W:0]   r_len,
  output logic              q_rd,
  output logic              r_rd,
  output logic [ADDR_W-1:0] q_addr,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [BASE_W-1:0] q_rdata,
  input  logic [BASE_W-1:0] r_rdata,
  output logic [BASE_W-1:0] q_in,
  output logic [BASE_W-1:0] r_in,
  output logic              q_en,
  output logic              r_en,
  output logic              q_dir,
  output logic              r_dir,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done
`ifdef SEQ_FEEDER_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int KW = ADDR_W + 2;
  localparam logic [KW-1:0] K_LAST = KW'(WIN - 1);

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   t_q;
  logic            win_valid_q;
  logic            en_q;
  logic            done_q;

  logic            start_acc;
  logic            accept;
  logic            issue;
  logic [ADDR_W:0] max_len;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign accept    = win_valid_q && win_ready;
  // In RUN the issue is combinational from win_ready so the shift lands in the next cycle.
  assign issue     = (state_q == ST_FILL) || (accept && (k_q < t_q));
  assign max_len   = (q_len >= r_len) ? q_len : r_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      t_q         <= '0;
      win_valid_q <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      en_q   <= issue;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FILL;
            k_q     <= '0;
            t_q     <= KW'(max_len) + KW'(WIN);
          end
        end
        ST_FILL: begin
          k_q <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          win_valid_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (!win_valid_q) begin
            win_valid_q <= 1'b1;
          end else if (win_ready) begin
            win_valid_q <= 1'b0;
            if (k_q < t_q) begin
              k_q <= k_q + 1'b1;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  seq_side_ctrl #(.ADDR_W(ADDR_W), .KW(KW)) u_q_side (
    .clk     (clk),
    .rst     (rst),
    .load_i  (start_acc),
    .len_i   (q_len),
    .issue_i (issue),
    .k_i     (k_q),
    .rd_o    (q_rd),
    .addr_o  (q_addr),
    .rdata_i (q_rdata),
    .base_o  (q_in)
  );

  seq_side_ctrl #(.ADDR_W(ADDR_W), .KW(KW)) u_r_side (
    .clk     (clk),
    .rst     (rst),
    .load_i  (start_acc),
    .len_i   (r_len),
    .issue_i (issue),
    .k_i     (k_q),
    .rd_o    (r_rd),
    .addr_o  (r_addr),
    .rdata_i (r_rdata),
    .base_o  (r_in)
  );

  assign q_en      = en_q;
  assign r_en      = en_q;
  assign q_dir     = 1'b0;
  assign r_dir     = 1'b1;
  assign win_valid = win_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

`ifdef SEQ_FEEDER_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if (win_valid_q && !win_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_seq_feeder.sv
// Bench for seq_feeder: RAM model, external shift-register model and a window scoreboard
// filled from the RAM contents at each start.
module tb_seq_feeder;
  import seq_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int WW     = WIN * BASE_W;

  typedef struct packed {
    logic [WW-1:0] q;
    logic [WW-1:0] r;
  } win_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   q_len;
  logic [ADDR_W:0]   r_len;
  logic              q_rd;
  logic              r_rd;
  logic [ADDR_W-1:0] q_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [BASE_W-1:0] q_rdata = '0;
  logic [BASE_W-1:0] r_rdata = '0;
  logic [BASE_W-1:0] q_in;
  logic [BASE_W-1:0] r_in;
  logic              q_en;
  logic              r_en;
  logic              q_dir;
  logic              r_dir;
  logic              win_valid;
  logic              win_ready;
  logic              busy;
  logic              done;
`ifdef SEQ_FEEDER_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  seq_feeder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .q_len     (q_len),
    .r_len     (r_len),
    .q_rd      (q_rd),
    .r_rd      (r_rd),
    .q_addr    (q_addr),
    .r_addr    (r_addr),
    .q_rdata   (q_rdata),
    .r_rdata   (r_rdata),
    .q_in      (q_in),
    .r_in      (r_in),
    .q_en      (q_en),
    .r_en      (r_en),
    .q_dir     (q_dir),
    .r_dir     (r_dir),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .busy      (busy),
    .done      (done)
`ifdef SEQ_FEEDER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  logic [BASE_W-1:0] q_mem [0:63];
  logic [BASE_W-1:0] r_mem [0:63];

  // Sequence RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (q_rd) q_rdata <= q_mem[q_addr[5:0]];
    if (r_rd) r_rdata <= r_mem[r_addr[5:0]];
  end

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  win_t          sb[$];
  logic [WW-1:0] qwin = '0;
  logic [WW-1:0] rwin = '0;
  int  exp_wins, exp_lat, exp_qr, exp_rr;
  int  win_cnt, q_rds, r_rds, stall_seen, start_cyc, last_acc;
  int  done_cnt = 0;
  int  stall_extra = 0;
  bit  start_real = 1'b0;
  bit  active = 1'b0;
  bit  first_seen = 1'b0;
  bit  done_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [BASE_W-1:0] exp_base(input bit side_r, input int len, input int k);
    if (k >= len) return BASE_PAD;
    return side_r ? r_mem[k] : q_mem[k];
  endfunction

  task automatic monitor();
    win_t w;
    int   t;
    if (win_valid && active && !first_seen) begin
      check_eq("first_valid_lat", 32'(cyc - start_cyc), 32'(WIN + 2));
      first_seen = 1'b1;
    end
    if (win_valid && !win_ready) begin
      check_eq("stall_no_shift", 32'(q_en), 0);
      stall_seen++;
    end
    if (win_valid && win_ready) begin
      if (sb.size() == 0) begin
        check_eq("extra_window", 32'(win_cnt + 1), 32'(exp_wins));
      end else begin
        w = sb.pop_front();
        check_eq("q_window", 32'(qwin), 32'(w.q));
        check_eq("r_window", 32'(rwin), 32'(w.r));
      end
      $display("cyc %0d window %0d q=%03h r=%03h", cyc, win_cnt, qwin, rwin);
      win_cnt++;
      last_acc = cyc;
    end
    if (q_en) qwin = {qwin[WW-BASE_W-1:0], q_in};
    if (r_en) rwin = {rwin[WW-BASE_W-1:0], r_in};
    if (q_rd) begin
      check_eq("q_addr", 32'(q_addr), 32'(q_rds));
      q_rds++;
    end
    if (r_rd) begin
      check_eq("r_addr", 32'(r_addr), 32'(r_rds));
      r_rds++;
    end
    if (done_prev) check_eq("done_width", 32'(done), 0);
    done_prev = done;
    if (done) begin
      check_eq("win_count", 32'(win_cnt), 32'(exp_wins));
      check_eq("done_after_accept", 32'(cyc - last_acc), 1);
      check_eq("done_latency", 32'(cyc - start_cyc), 32'(exp_lat));
      check_eq("q_reads", 32'(q_rds), 32'(exp_qr));
      check_eq("r_reads", 32'(r_rds), 32'(exp_rr));
      check_eq("busy_at_done", 32'(busy), 0);
      done_cnt++;
      active = 1'b0;
    end
    if (start && start_real && !rst) begin
      t = ((int'(q_len) > int'(r_len)) ? int'(q_len) : int'(r_len)) + WIN;
      for (int wi = 0; wi <= t - WIN; wi++) begin
        w = '0;
        for (int j = 0; j < WIN; j++) begin
          w.q = {w.q[WW-BASE_W-1:0], exp_base(1'b0, int'(q_len), wi + j)};
          w.r = {w.r[WW-BASE_W-1:0], exp_base(1'b1, int'(r_len), wi + j)};
        end
        sb.push_back(w);
      end
      exp_wins   = t - WIN + 1;
      exp_lat    = WIN + 3 + 2 * (exp_wins - 1) + stall_extra;
      exp_qr     = int'(q_len);
      exp_rr     = int'(r_len);
      start_cyc  = cyc;
      win_cnt    = 0;
      q_rds      = 0;
      r_rds      = 0;
      stall_seen = 0;
      first_seen = 1'b0;
      active     = 1'b1;
    end
    if (rst) begin
      sb.delete();
      active = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctl"}, 32'({q_rd, r_rd, q_en, r_en, win_valid, busy, done}), 0);
    check_eq({tag, "_addr"}, 32'({q_addr, r_addr}), 0);
    check_eq({tag, "_base"}, 32'({q_in, r_in}), 32'({BASE_PAD, BASE_PAD}));
    check_eq({tag, "_dir"}, 32'({q_dir, r_dir}), 32'h1);
`ifdef SEQ_FEEDER_STATS_EN
    check_eq({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
`endif
  endtask

  task automatic run(input int ql, input int rl, input int extra);
    q_len       = LEN_W'(ql);
    r_len       = LEN_W'(rl);
    stall_extra = extra;
    start       = 1'b1;
    start_real  = 1'b1;
    tick();
    start      = 1'b0;
    start_real = 1'b0;
  endtask

  task automatic wait_done();
    int target;
    target = done_cnt + 1;
    for (int i = 0; i < 2000 && done_cnt < target; i++) tick();
    if (done_cnt < target) check_eq("done_timeout", 32'(done_cnt), 32'(target));
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; q_len = '0; r_len = '0; win_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      q_mem[i] = BASE_N;
      r_mem[i] = BASE_N;
    end
    #1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset("reset");
    tick();

    // Q=ACGT, R=TTGA
    q_mem[0] = BASE_A; q_mem[1] = BASE_C; q_mem[2] = BASE_G; q_mem[3] = BASE_T;
    r_mem[0] = BASE_T; r_mem[1] = BASE_T; r_mem[2] = BASE_G; r_mem[3] = BASE_A;
    run(4, 4, 0);
    wait_done();

    run(0, 0, 0);
    wait_done();

    for (int i = 0; i < 64; i++) begin
      q_mem[i] = 3'($urandom_range(1, 5));
      r_mem[i] = 3'($urandom_range(1, 5));
    end
    run(6, 2, 0);
    wait_done();

    // Hold the first window for 20 cycles.
    win_ready = 1'b0;
    run(4, 3, 20);
    repeat (25) tick();
    win_ready = 1'b1;
    wait_done();
    check_eq("stall_cycles", 32'(stall_seen), 20);
`ifdef SEQ_FEEDER_STATS_EN
    check_eq("stall_cnt", 32'(stall_cnt), 20);
`endif

    // Reset three cycles into RUN, then a clean run.
    run(6, 6, 0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("mid_rst");
    tick();
    run(5, 7, 0);
    wait_done();

    // A start while busy must not disturb the current run.
    run(3, 5, 0);
    repeat (3) tick();
    q_len = LEN_W'(9);
    r_len = LEN_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check_eq("idle_after_runs", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
